// File: rtl/dff_arb_pkg.sv
// Shared definitions for the shared-register round-robin arbiter:
// state encodings, default sizes and a constant-safe clog2.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_ACK   = 2'b10
  } arb_state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  // Smallest r with 2**r >= n; bounded loop so it stays elaboration-friendly.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit D register with load enable and asynchronous clear.
// qb is a pure complement of the stored value, not separate storage.
module dff_reg
  import dff_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] q_q;

  // Storage cell: cleared on reset, loads d only when enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= {WIDTH{1'b0}};
    end else if (en) begin
      q_q <= d;
    end else begin
      q_q <= q_q;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one storage register among NREQ requesters.
// Each access runs IDLE -> GRANT -> ACK; all outputs come from registers.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wr_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qb,
  output logic                     busy,
  output logic [clog2(NREQ)-1:0]   last_id
);

  localparam int IDW = clog2(NREQ);
  localparam logic [IDW-1:0]  ZERO_ID  = IDW'(0);
  localparam logic [IDW-1:0]  ONE_ID   = IDW'(1);
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
  localparam logic [NREQ-1:0] NO_REQ   = NREQ'(0);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   win_q, win_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             commit_s;
  logic [WIDTH-1:0] wr_slice_s;

  // First set request at or above p, wrapping; descending scan lets the nearest win.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  p);
    logic [IDW-1:0] w;
    int             idx;
    w = p;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(p) + off;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (r[idx[IDW-1:0]]) begin
        w = idx[IDW-1:0];
      end
    end
    return w;
  endfunction

  assign wr_slice_s = wr_data[int'(win_q)*WIDTH +: WIDTH];
  assign commit_s   = (state_q == ST_GRANT) && req[win_q];

  // Next-state, pointer bookkeeping and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rr_ptr_d  = rr_ptr_q;
    last_id_d = last_id_q;
    gnt_d     = NO_REQ;
    ack_d     = NO_REQ;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d   = rr_pick(req, rr_ptr_q);
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A requester that let go before the closing edge forfeits its slot.
        if (commit_s) begin
          last_id_d = win_q;
          rr_ptr_d  = (win_q == LAST_ID) ? ZERO_ID : (win_q + ONE_ID);
          state_d   = ST_ACK;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_GRANT) begin
      gnt_d = ONE_HOT0 << win_d;
    end else begin
      gnt_d = NO_REQ;
    end
    if (state_d == ST_ACK) begin
      ack_d = ONE_HOT0 << win_q;
    end else begin
      ack_d = NO_REQ;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      win_q     <= ZERO_ID;
      rr_ptr_q  <= ZERO_ID;
      last_id_q <= ZERO_ID;
      gnt_q     <= NO_REQ;
      ack_q     <= NO_REQ;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rr_ptr_q  <= rr_ptr_d;
      last_id_q <= last_id_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  dff_reg #(.WIDTH(WIDTH)) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (commit_s),
    .d       (wr_slice_s),
    .q       (q),
    .qb      (qb)
  );

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign last_id = last_id_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: expected commits are queued when a
// request is driven and retired by a monitor whenever ack pulses.
module tb_dff_bank_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic [7:0]  qb;
  logic        busy;
  logic [1:0]  last_id;

  int total;
  int bad;

  typedef struct packed {
    logic [3:0] oh;
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .wr_data (wr_data),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .qb      (qb),
    .busy    (busy),
    .last_id (last_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Retire one expected commit per ack pulse
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {28'h0, ack}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ack", {28'h0, ack}, {28'h0, e.oh});
        chk("sb_q", {24'h0, q}, {24'h0, e.data});
        chk("sb_qb", {24'h0, qb}, {24'h0, ~e.data});
        chk("sb_last_id", {30'h0, last_id}, {30'h0, e.id});
      end
    end
  end

  // Starting from IDLE with req already driven: grant, commit, back to idle
  task automatic run_xact(input int id, input logic [7:0] data, input logic [3:0] req_after);
    logic [3:0] oh;
    exp_t       e;
    oh = 4'b0001 << id;
    e.oh = oh;
    e.data = data;
    e.id = 2'(id);
    sb.push_back(e);
    tick();
    chk("gnt", {28'h0, gnt}, {28'h0, oh});
    chk("busy_grant", {31'h0, busy}, 32'h1);
    chk("ack_in_grant", {28'h0, ack}, 32'h0);
    tick();
    chk("ack", {28'h0, ack}, {28'h0, oh});
    chk("q_commit", {24'h0, q}, {24'h0, data});
    chk("gnt_in_ack", {28'h0, gnt}, 32'h0);
    req = req_after;
    tick();
    chk("busy_idle", {31'h0, busy}, 32'h0);
    chk("ack_idle", {28'h0, ack}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    req     = 4'b0000;
    wr_data = {8'h43, 8'h3C, 8'h21, 8'hA5};
    repeat (2) tick();
    reset_n = 1'b1;
    chk("rst_q", {24'h0, q}, 32'h00);
    chk("rst_qb", {24'h0, qb}, 32'hFF);
    chk("rst_gnt", {28'h0, gnt}, 32'h0);
    chk("rst_ack", {28'h0, ack}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_last_id", {30'h0, last_id}, 32'h0);

    // Reset asserted while requester 0 holds a grant
    req = 4'b0001;
    tick();
    chk("pre_rst_gnt", {28'h0, gnt}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midrst_gnt", {28'h0, gnt}, 32'h0);
    chk("midrst_q", {24'h0, q}, 32'h00);
    chk("midrst_qb", {24'h0, qb}, 32'hFF);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    tick();
    chk("midrst_no_ack", {28'h0, ack}, 32'h0);
    reset_n = 1'b1;
    req = 4'b0000;
    wr_data[7:0] = 8'h10;
    tick();
    chk("postrst_no_ack", {28'h0, ack}, 32'h0);
    chk("postrst_q", {24'h0, q}, 32'h00);

    // Single requester 2
    req = 4'b0100;
    run_xact(2, 8'h3C, 4'b0000);
    chk("single_last_id", {30'h0, last_id}, 32'h2);
    chk("single_qb", {24'h0, qb}, 32'hC3);

    // Commit by 3 so the pointer wraps to 0, then 1 beats 3
    req = 4'b1000;
    run_xact(3, 8'h43, 4'b0000);
    req = 4'b1010;
    run_xact(1, 8'h21, 4'b1000);
    run_xact(3, 8'h43, 4'b0000);

    // Everyone requesting: strict rotation, one commit every three cycles
    wr_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1111;
    run_xact(0, 8'h10, 4'b1111);
    run_xact(1, 8'h21, 4'b1111);
    run_xact(2, 8'h32, 4'b1111);
    run_xact(3, 8'h43, 4'b1111);
    run_xact(0, 8'h10, 4'b0000);

    // Abort: requester 1 drops during GRANT; pointer must stay at 1
    req = 4'b0010;
    tick();
    chk("abort_gnt", {28'h0, gnt}, 32'h2);
    req = 4'b0000;
    tick();
    chk("abort_no_ack", {28'h0, ack}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_q", {24'h0, q}, 32'h10);
    chk("abort_last_id", {30'h0, last_id}, 32'h0);
    tick();
    chk("abort_still_no_ack", {28'h0, ack}, 32'h0);
    req = 4'b0011;
    run_xact(1, 8'h21, 4'b0000);

    // Late release: 0 keeps req through ACK while 2 arrives; 2 goes first
    req = 4'b1000;
    run_xact(3, 8'h43, 4'b0000);
    req = 4'b0001;
    run_xact(0, 8'h10, 4'b0101);
    run_xact(2, 8'h32, 4'b0001);
    run_xact(0, 8'h10, 4'b0000);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 32'h0);
    chk("final_busy", {31'h0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit D flip-flop storage register (Q/Q' outputs) between NREQ requesters.
- Sequences each access as request, then grant, then commit, then acknowledge, so only one requester's data is clocked into the register per transaction.
- Sits between the lab's requester stimulus/control logic and the shared storage cell bank.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, storage register width in bits

Ports:
clk  input  1  single system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester write request, level, held until ack or abandoned
wr_data  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, high for exactly the GRANT cycle
ack  output  NREQ  one-hot commit acknowledge, one-cycle pulse
q  output  WIDTH  shared register contents
qb  output  WIDTH  bitwise complement of q, always equal to ~q
busy  output  1  high in GRANT and ACK states
last_id  output  clog2(NREQ)  index of the last requester that committed

Behaviour:
- Reset (async, reset_n=0, takes effect immediately, mid-transaction included):
  - state=IDLE, q=0, qb=all ones, gnt=0, ack=0, busy=0, last_id=0, rr_ptr=0.
  - No pending write survives reset.
- States: IDLE, GRANT, ACK. Encoding: 2-bit, IDLE=00, GRANT=01, ACK=10. Code 11 is illegal and returns to IDLE on the next edge.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner w: the first set req bit searching upward from rr_ptr, wrapping from NREQ-1 to 0.
  - Latch w, go to GRANT.
- GRANT (one cycle):
  - gnt[w]=1, busy=1.
  - If req[w] is still 1 at the closing edge:
    - q <= wr_data slice w;
    - last_id <= w;
    - rr_ptr <= (w+1) mod NREQ;
    - go to ACK.
  - If req[w] has dropped: abort. q, last_id and rr_ptr are unchanged; go to IDLE; no ack is issued.
- ACK (one cycle):
  - ack[w]=1, busy=1, q already shows the new value.
  - Always go to IDLE.
  - The requester must drop req[w] by the edge closing ACK. If it does not, it competes again from IDLE with lowest priority.
- Latency: req seen in IDLE at edge k; gnt high in cycle k+1; q updated and ack high in cycle k+2; IDLE again in cycle k+3. Minimum transaction is 3 cycles.
- New requests during GRANT/ACK are not sampled; they are evaluated on the return to IDLE.
- Round-robin fairness: with all requests held continuously, grants rotate 0,1,...,NREQ-1,0.
- A single continuous requester is granted every 3 cycles.
- Outputs are registered or derived from state only. gnt/ack have no combinational path from req.
- qb is derived as ~q and has no independent storage.

Decomposition:
- Shared package `dff_arb_pkg` holds:
  - state encodings ST_IDLE/ST_GRANT/ST_ACK;
  - default NREQ/WIDTH;
  - the clog2 helper function.
- Sub-module `dff_reg`: WIDTH-bit D register with enable.
  - Ports: clk, reset_n, en, d, q, qb.
  - Async active-low clear to q=0.
  - Instantiated once as the shared storage.
- The round-robin winner search is a combinational function in the arbiter, not a separate module.

Test Plan:
- Reset mid-transaction: req=4'b0001, wr_data[7:0]=8'hA5; assert reset_n=0 during GRANT -> gnt=0, q=8'h00, qb=8'hFF immediately; no ack follows.
- Single requester: req=4'b0100, wr_data slice 2=8'h3C -> gnt=4'b0100 at k+1; q=8'h3C, qb=8'hC3, ack=4'b0100, last_id=2 at k+2; busy low at k+3.
- All requesting: req=4'b1111 held, slices = 8'h10, 8'h21, 8'h32, 8'h43 -> grants in order 0,1,2,3,0; q sequence 10,21,32,43,10; one commit every 3 cycles.
- Wrap-around priority: after a commit by id 3 (rr_ptr=0), req=4'b1010 -> id 1 granted before id 3.
- Abort: req[1] granted, then dropped during GRANT -> no ack, q unchanged, rr_ptr unchanged; a subsequent req=4'b0010 is granted to id 1.
- Late release: requester 0 holds req through ACK while req[2] is also set -> next grant goes to id 2, then id 0.
